// File: rtl/fofb_readout_sequencer_if.sv
// Stream and microBlaze read-port bundle of the FOFB readout sequencer.
interface fofb_readout_sequencer_if #(
    parameter int IDX_W  = 9,
    parameter int DATA_W = 96
);
    // Stream: one transfer on every rising edge where outValid && outReady; while outValid is high
    // and outReady low, outIndex/outData hold. uB: uBreq/uBaddr are held until the one-cycle uBack,
    // and uBdata/uBpresent are valid on the uBack cycle and stay put afterwards.
    logic [IDX_W-1:0]  outIndex;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic              uBreq;
    logic [IDX_W-1:0]  uBaddr;
    logic              uBack;
    logic [DATA_W-1:0] uBdata;
    logic              uBpresent;

    modport master (
        output outIndex, outData, outValid, uBack, uBdata, uBpresent,
        input  outReady, uBreq, uBaddr
    );
    modport slave (
        input  outIndex, outData, outValid, uBack, uBdata, uBpresent,
        output outReady, uBreq, uBaddr
    );
endinterface

// File: rtl/fofb_readout_sequencer.sv
// Shares the single FOFB readout memory read port between the per-frame stream scan and uB reads.
// Optional statistics counters are built when READOUT_SEQ_STATS_EN is defined.
module fofb_readout_sequencer #(
    parameter int FOFB_INDEX_WIDTH = 9,
    parameter int DATA_WIDTH       = 96,
    parameter int UB_MAX_WAIT      = 8
) (
    input  logic                        sysClk,
    input  logic                        sysResetN,
    input  logic                        readoutActive,
    input  logic                        readoutValid,
    output logic [FOFB_INDEX_WIDTH-1:0] ramAddress,
    input  logic [DATA_WIDTH-1:0]       ramData,
    input  logic                        ramPresent,
    fofb_readout_sequencer_if.master    bus,
    output logic                        frameDone,
    output logic                        busy,
    output logic [1:0]                  dbgState
`ifdef READOUT_SEQ_STATS_EN
    ,
    output logic [15:0]                 statFrames,
    output logic [7:0]                  statAborts,
    output logic [FOFB_INDEX_WIDTH:0]   statPresent
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_WAITLOW = 2'd3
    } state_e;

    localparam logic [FOFB_INDEX_WIDTH-1:0] LAST_ADDR   = '1;
    localparam logic [7:0]                  UB_WAIT_MAX = 8'(UB_MAX_WAIT);

    state_e                        state_q, state_d;
    logic [FOFB_INDEX_WIDTH-1:0]   scan_addr_q, scan_addr_d;
    logic                          frame_lvl_q;
    logic                          frame_start_q;
    logic                          frame_done_q, frame_done_d;

    logic                          rd_vld_q;
    logic                          rd_ub_q;
    logic [FOFB_INDEX_WIDTH-1:0]   rd_idx_q;

    logic [FOFB_INDEX_WIDTH-1:0]   fifo_idx_q  [2];
    logic [DATA_WIDTH-1:0]         fifo_data_q [2];
    logic                          wr_ptr_q, rd_ptr_q;
    logic [1:0]                    count_q;

    logic [7:0]                    ub_wait_q;
    logic [DATA_WIDTH-1:0]         ub_data_q;
    logic                          ub_present_q;

    logic                          abort;
    logic                          scan_ret, ub_ret;
    logic                          push, pop;
    logic                          fifo_valid;
    logic [1:0]                    occ_after;
    logic                          fifo_room;
    logic                          ub_pending, ub_grant, scan_issue;

    assign abort      = readoutActive && (state_q == ST_SCAN || state_q == ST_DRAIN);
    assign scan_ret   = rd_vld_q && !rd_ub_q;
    assign ub_ret     = rd_vld_q && rd_ub_q;
    assign fifo_valid = (count_q != 2'd0);
    assign push       = scan_ret && ramPresent && !abort;
    assign pop        = fifo_valid && bus.outReady;

    // Room is judged on occupancy after this cycle's pop so that a held-high outReady sustains one entry per cycle.
    assign occ_after  = count_q - {1'b0, pop} + {1'b0, scan_ret};
    assign fifo_room  = (occ_after < 2'd2);

    // uBreq stays high through the uBack cycle, so a returning uB read blocks a second grant.
    assign ub_pending = bus.uBreq && !ub_ret;
    assign ub_grant   = ub_pending &&
                        (state_q != ST_SCAN || !fifo_room || ub_wait_q >= UB_WAIT_MAX || abort);
    assign scan_issue = (state_q == ST_SCAN) && !abort && fifo_room && !ub_grant;
    assign ramAddress = ub_grant ? bus.uBaddr : scan_addr_q;

    always_comb begin
        state_d      = state_q;
        scan_addr_d  = scan_addr_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_q) begin
                    state_d     = ST_SCAN;
                    scan_addr_d = '0;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (scan_issue) begin
                    scan_addr_d = scan_addr_q + FOFB_INDEX_WIDTH'(1);
                    if (scan_addr_q == LAST_ADDR) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!scan_ret && count_q == 2'd0) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_WAITLOW;
                end
            end
            ST_WAITLOW: begin
                if (!readoutValid || readoutActive) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            state_q       <= ST_IDLE;
            scan_addr_q   <= '0;
            frame_lvl_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_ub_q       <= 1'b0;
            rd_idx_q      <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            ub_wait_q     <= 8'd0;
            ub_data_q     <= '0;
            ub_present_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_addr_q   <= scan_addr_d;
            frame_lvl_q   <= readoutValid && !readoutActive;
            frame_start_q <= readoutValid && !readoutActive && !frame_lvl_q;
            frame_done_q  <= frame_done_d;
            rd_vld_q      <= ub_grant || scan_issue;
            rd_ub_q       <= ub_grant;
            rd_idx_q      <= scan_addr_q;

            if (ub_grant) begin
                ub_wait_q <= 8'd0;
            end else if (!bus.uBreq) begin
                ub_wait_q <= 8'd0;
            end else if (ub_pending && ub_wait_q < UB_WAIT_MAX) begin
                ub_wait_q <= ub_wait_q + 8'd1;
            end

            if (ub_ret) begin
                ub_data_q    <= ramData;
                ub_present_q <= ramPresent;
            end

            if (abort) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (push) wr_ptr_q <= !wr_ptr_q;
                if (pop)  rd_ptr_q <= !rd_ptr_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // FIFO storage needs no reset: the head is only visible while the occupancy count is non-zero.
    always_ff @(posedge sysClk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q]  <= rd_idx_q;
            fifo_data_q[wr_ptr_q] <= ramData;
        end
    end

    assign bus.outValid  = fifo_valid;
    assign bus.outIndex  = fifo_valid ? fifo_idx_q[rd_ptr_q]  : '0;
    assign bus.outData   = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.uBack     = ub_ret;
    assign bus.uBdata    = ub_ret ? ramData : ub_data_q;
    assign bus.uBpresent = ub_ret ? ramPresent : ub_present_q;
    assign frameDone     = frame_done_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbgState      = state_q;

`ifdef READOUT_SEQ_STATS_EN
    logic [15:0]                 stat_frames_q;
    logic [7:0]                  stat_aborts_q;
    logic [FOFB_INDEX_WIDTH:0]   stat_present_q;
    logic [FOFB_INDEX_WIDTH:0]   cur_present_q;

    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            stat_frames_q  <= 16'd0;
            stat_aborts_q  <= 8'd0;
            stat_present_q <= '0;
            cur_present_q  <= '0;
        end else begin
            if (frame_done_d) begin
                stat_frames_q  <= stat_frames_q + 16'd1;
                stat_present_q <= cur_present_q;
            end
            if (abort && stat_aborts_q != 8'hFF) stat_aborts_q <= stat_aborts_q + 8'd1;
            if (state_q == ST_IDLE) begin
                cur_present_q <= '0;
            end else if (push) begin
                cur_present_q <= cur_present_q + (FOFB_INDEX_WIDTH + 1)'(1);
            end
        end
    end

    assign statFrames  = stat_frames_q;
    assign statAborts  = stat_aborts_q;
    assign statPresent = stat_present_q;
`endif

endmodule

// File: doc/fofb_readout_sequencer.md
Name: fofb_readout_sequencer

Overview:
- Controller that shares the single-read-port FOFB readout memory between two requesters: the per-frame DSP streaming scan and microBlaze random-access reads.
- Sits between the link-reader readout memory (address/X-Y-S data/present flag) and the FOFB correction DSP stream.
- Each time a new readout frame becomes valid, it sequences addresses 0..2^FOFB_INDEX_WIDTH-1, skips absent entries, and delivers present entries over a ready/valid stream.
- MicroBlaze reads are interleaved under a starvation guard.

Parameters:
- FOFB_INDEX_WIDTH, 9, readout memory address width; scan length is 2^FOFB_INDEX_WIDTH.
- DATA_WIDTH, 96, readout word width ({X,Y,S}).
- UB_MAX_WAIT, 8, maximum cycles a pending uB request may be deferred by the scan (range 1..255).

Ports:
- sysClk  in  1  system clock; all logic on rising edge.
- sysResetN  in  1  synchronous, active-low reset.
- readoutActive  in  1  high while the link reader is filling the memory.
- readoutValid  in  1  high when the memory holds a complete frame.
- ramAddress  out  FOFB_INDEX_WIDTH  memory read address.
- ramData  in  DATA_WIDTH  memory data, 1 cycle after ramAddress.
- ramPresent  in  1  entry-present flag, 1 cycle after ramAddress.
- uBreq  in  1  uB read request; held until uBack.
- uBaddr  in  FOFB_INDEX_WIDTH  uB read address, stable while uBreq is high.
- uBack  out  1  one-cycle pulse; uBdata/uBpresent valid on this cycle and held afterwards.
- uBdata  out  DATA_WIDTH  uB read data.
- uBpresent  out  1  uB read present flag.
- outIndex  out  FOFB_INDEX_WIDTH  stream entry address.
- outData  out  DATA_WIDTH  stream entry data.
- outValid  out  1  stream valid.
- outReady  in  1  stream ready; a transfer occurs when outValid && outReady.
- frameDone  out  1  one-cycle pulse when a scan completes and the output is drained.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset (sysResetN=0 at an edge): state IDLE; all outputs 0; output FIFO emptied; in-flight read discarded; uB wait counter 0; stats counters 0.
- Frame start is detected on the rising edge of (readoutValid && !readoutActive), registered. This allows exactly one scan per frame.
- FSM states:
  - IDLE: on frame start go to SCAN with scan address 0.
  - SCAN: issue scan reads. After the read of the last address (all ones) is issued, go to DRAIN.
  - DRAIN: wait until the in-flight read returns and the FIFO is empty, then pulse frameDone for one cycle and go to WAITLOW.
  - WAITLOW: go to IDLE when readoutValid=0 or readoutActive=1.
- Abort: readoutActive=1 in SCAN or DRAIN forces an immediate return to IDLE.
  - FIFO flushed the same cycle; outValid=0 next cycle.
  - The in-flight scan read is discarded.
  - No frameDone pulse.
  - A uB read already in flight still completes.
- Read port: at most one read issued per cycle; fixed latency 1.
  - A tag register records the owner (scan or uB) and the scan index.
- Output buffer: 2-entry FIFO.
  - Scan read issue condition: FIFO occupancy + in-flight scan reads < 2.
  - Returned scan data is pushed only if ramPresent=1; absent entries are dropped silently.
  - Sustained throughput is 1 entry/cycle with outReady held high.
  - outIndex/outData/outValid come from the FIFO head; they are stable while outValid && !outReady.
- Arbitration per cycle:
  - If uBreq is pending, no uB read is in flight, and (state is not SCAN, or the scan is stalled by the FIFO condition, or uB wait counter = UB_MAX_WAIT), the uB read is issued.
  - Otherwise the scan read is issued.
  - The uB wait counter increments each cycle uBreq is pending and not granted; it clears on grant.
  - A uB grant in SCAN does not advance the scan address.
- uB completion: uBack pulses 1 cycle after the uB read is issued, with uBdata=ramData and uBpresent=ramPresent registered on that cycle. uBreq is sampled again only after uBack, so there are no duplicate grants.
- Simultaneous abort and uB grant: uB is granted; the scan stops.

Optional Feature:
- Macro READOUT_SEQ_STATS_EN.
- When defined, adds outputs:
  - statFrames[15:0]: wraps; counts frameDone pulses.
  - statAborts[7:0]: saturates at 255.
  - statPresent[FOFB_INDEX_WIDTH:0]: count of present entries in the last completed frame, updated at frameDone.
- All three clear on reset.
- When not defined, these ports and counters do not exist.

Test Plan (FOFB_INDEX_WIDTH=3, UB_MAX_WAIT=4):
- Entries 1, 4, 7 present; frame start; outReady=1 → stream indices 1, 4, 7 with matching data; frameDone 1 cycle after the last read returns and the FIFO drains; exactly one frameDone.
- All 8 entries present; outReady toggles 1,0,1,0 → 8 transfers in order 0..7; outData stable while stalled; no FIFO overflow.
- uBreq addr=5 held from scan start with outReady=1 → uBack within 5 cycles; uBdata equals memory[5]; stream still delivers all present entries.
- readoutActive pulses high after 3 stream transfers → outValid=0 next cycle; no frameDone; statAborts=1 (stats build).
- readoutValid held high after frameDone → no second scan; drop readoutValid, then raise it again → new scan.
- sysResetN=0 mid-scan with outValid=1 → next cycle outValid=0, busy=0, uBack=0, state IDLE.
